div_iter: RTL
=============

Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider used in the EX stage for DIV/DIVU.
- It produces the ready handshake that the hazard unit consumes as divreadyE, with divstallE = isdivE & ~divreadyE.
- While the EX stage is stalled, the pipeline holds the operands and start steady.
- The block returns {remainder, quotient} for forwarding into HI/LO, and supports a flush abort on exceptions.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  division requested (isdivE); held high by the pipeline until ready
signed_div  in  1  1 = DIV (signed), 0 = DIVU
opdata1  in  WIDTH  dividend (rs)
opdata2  in  WIDTH  divisor (rt)
annul  in  1  abort the current operation (exceptflush)
result  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; HI = remainder, LO = quotient
ready  out  1  one-cycle pulse; result is valid
busy  out  1  high in DIVZERO, ON and DONE

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE, counter=0, ready=0, busy=0, result=0, internal registers 0.
- States: IDLE, DIVZERO, ON, DONE. annul has highest priority: from any state the next state is IDLE, with ready=0 on that edge and the next.
- IDLE:
  - If start & ~annul and opdata2==0 → DIVZERO.
  - If start & ~annul and opdata2!=0 → ON. On this edge latch:
    - |opdata1| and |opdata2| (absolute values only when signed_div=1);
    - sign of the quotient: opdata1[MSB]^opdata2[MSB], signed only;
    - sign of the remainder: opdata1[MSB], signed only.
    - Clear the remainder accumulator and counter.
  - Otherwise stay in IDLE.
- DIVZERO: one cycle, then DONE. result = {opdata1 as latched, all-ones quotient}.
- ON: one restoring iteration per edge.
  - Shift {rem, dvd} left by one.
  - Trial-subtract the divisor from the WIDTH+1-bit partial remainder.
  - If non-negative, keep the difference and set quotient bit 1; else restore and set bit 0.
  - The counter increments; after the WIDTH-th iteration edge → DONE.
  - Final sign correction (two's-complement negate of quotient and/or remainder) is applied on the edge entering DONE.
- DONE:
  - ready=1 for exactly this cycle; result registered and stable.
  - Next edge → IDLE unconditionally. start is still high from the same instruction here and must NOT restart the divider.
- Latency: the cycle in which start is first seen in IDLE is cycle 0.
  - Divisor nonzero: ready high in cycle WIDTH+1, i.e. cycle 33.
  - Divisor zero: ready high in cycle 2.
- result holds its value after DONE until the next accepted start or reset. ready is 0 in every state except DONE.
- Back-to-back divisions: start high in the IDLE cycle after DONE (the next DIV now in EX) is accepted normally. Zero bubbles are added beyond the DONE→IDLE cycle.
- Arithmetic:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed -2^31 / -1 → quotient 0x80000000 (wraps), remainder 0.
  - Absolute value of -2^31 is 0x80000000, treated as unsigned.
- Operand changes during ON/DONE are ignored; the operands latched at start are used.
- annul while start is also high: annul wins. The block stays or returns to IDLE. start is re-evaluated only on the following edge.

Test Plan:
- Reset mid-ON (resetn low at cycle 10) → ready=0 and result=0 immediately (async); after release, start is accepted in IDLE.
- DIVU 100 / 7, start held → ready pulses only in cycle 33; result={0x00000002, 0x0000000E}; ready=0 in cycle 34 and state is IDLE; no restart while start stays high in cycle 33.
- DIV -7 / 2 (0xFFFFFFF9 / 2) → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); DIV 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; DIVU 0x80000000 / 0xFFFFFFFF → quotient 0, remainder 0x80000000.
- Divide by zero, DIVU 0x1234 / 0 → ready in cycle 2; result={0x00001234, 0xFFFFFFFF}.
- annul at cycle 15 of a division → IDLE next edge, no ready pulse. A new start of 9/3 in the following cycle → ready in cycle 33 after acceptance with quotient 3, remainder 0. Then back-to-back 10/4 is started in the IDLE cycle after DONE → quotient 2, remainder 2.

Source files
------------

// File: rtl/div_iter_if.sv
// Handshake/bus bundle between the EX stage and the iterative divider.
//   start/signed_div/opdata1/opdata2/annul : request side, driven by the pipeline
//   result/ready/busy                      : response side, driven by the divider
interface div_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               annul;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               busy;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready, busy
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready, busy
  );
endinterface

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : div_iter_if slave -- start/signed_div/opdata1/opdata2/annul in,
//            result {remainder, quotient}, ready (1-cycle pulse), busy out
// Latency from the accepting IDLE cycle: WIDTH+1 cycles, or 2 for a zero divisor.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       resetn,
  div_iter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     abs1_c, abs2_c;
  logic [WIDTH:0]       shift_c;
  logic                 ge_c;
  logic [WIDTH-1:0]     diff_c;
  logic [WIDTH-1:0]     rem_n_c, quo_n_c;
  logic [WIDTH-1:0]     q_fin_c, r_fin_c;

  // Operand magnitudes; -2^(WIDTH-1) maps onto itself and is then read as unsigned.
  assign abs1_c = (bus.signed_div && bus.opdata1[WIDTH-1]) ? (~bus.opdata1 + WIDTH'(1)) : bus.opdata1;
  assign abs2_c = (bus.signed_div && bus.opdata2[WIDTH-1]) ? (~bus.opdata2 + WIDTH'(1)) : bus.opdata2;

  // One restoring step: the shifted partial remainder is below 2*divisor, so when
  // it is >= divisor the difference fits in WIDTH bits.
  assign shift_c = {rem_q, dvd_q[WIDTH-1]};
  assign ge_c    = (shift_c >= {1'b0, dvs_q});
  assign diff_c  = shift_c[WIDTH-1:0] - dvs_q;
  assign rem_n_c = ge_c ? diff_c : shift_c[WIDTH-1:0];
  assign quo_n_c = {dvd_q[WIDTH-2:0], ge_c};

  // Sign correction applied on the final iteration.
  assign q_fin_c = qneg_q ? (~quo_n_c + WIDTH'(1)) : quo_n_c;
  assign r_fin_c = rneg_q ? (~rem_n_c + WIDTH'(1)) : rem_n_c;

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.annul) begin
          if (bus.opdata2 == '0) begin
            state_d = DIVZERO;
            dvd_d   = bus.opdata1;
          end else begin
            state_d = ON;
            dvd_d   = abs1_c;
            dvs_d   = abs2_c;
            qneg_d  = bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
            rneg_d  = bus.signed_div & bus.opdata1[WIDTH-1];
            rem_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      DIVZERO: begin
        state_d  = DONE;
        result_d = {dvd_q, {WIDTH{1'b1}}};
      end
      ON: begin
        rem_d = rem_n_c;
        dvd_d = quo_n_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = {r_fin_c, q_fin_c};
        end
      end
      DONE: begin
        // start is still high from the finishing instruction; never restart here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.annul) begin
      state_d = IDLE;
    end
  end

  assign ready_d = (state_d == DONE);
  assign busy_d  = (state_d != IDLE);

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;

endmodule
